lif_spike_scheduler: RTL and testbench
======================================

// Module: lif_spike_scheduler
// PURPOSE
//   Time-multiplexed LIF neuron controller for one layer. Holds N membrane
//   potentials, accumulates synaptic weights into them, and once per timestep
//   sweeps all neurons through one shared threshold comparator.
//   Emits a spike event per firing neuron and a per-step spike vector.
//   Sits between the synapse/weight fetch stage and the next layer's input queue.
// PARAMETERS
//   N_NEURONS   16  neurons served (>=2)
//   IDX_W       4   index width, clog2(N_NEURONS)
//   LEAK_SHIFT  3   leak = mem >> LEAK_SHIFT (used only with LEAK_EN)
// PORTS
//   clk         in   1          clock, rising edge
//   rst_n       in   1          async active-low reset
//   threshold   in   8          signed firing threshold, sampled at step_start
//   syn_valid   in   1          synaptic weight offered
//   syn_ready   out  1          weight accepted when valid&ready
//   syn_idx     in   IDX_W      target neuron
//   syn_weight  in   8          signed weight
//   step_start  in   1          begin timestep evaluation (pulse)
//   busy        out  1          scan in progress
//   step_done   out  1          1-cycle pulse, scan complete
//   spk_valid   out  1          1-cycle spike event
//   spk_idx     out  IDX_W      neuron that fired
//   spk_vec     out  N_NEURONS  spikes of last completed step
// BEHAVIOUR
//   Reset: all mem=0, state IDLE, syn_ready=1, busy/step_done/spk_valid=0,
//     spk_idx=0, spk_vec=0. Reset mid-scan aborts; no step_done issued.
//   Membrane: 8-bit unsigned. Accumulate mem+weight in 10-bit signed, then
//     clamp to 0..255 (no wrap).
//   FSM IDLE -> SCAN -> DONE -> IDLE.
//   IDLE: syn_ready=1; valid&ready updates mem[syn_idx] at that edge.
//     syn_idx >= N_NEURONS: handshake completes, weight dropped.
//     step_start: latch threshold, clear spk_vec, scan ptr=0, go SCAN.
//     syn+step_start same cycle: weight applied, scan sees updated value.
//   SCAN: syn_ready=0, busy=1; one neuron per cycle, ptr 0..N_NEURONS-1.
//     Fire iff {1'b0,mem} >= sign-extended threshold (9-bit signed
//     compare; equal fires; negative threshold always fires).
//     Fire: mem<=0, spk_vec[ptr]<=1, spk_valid=1 & spk_idx=ptr next cycle.
//     No fire: mem held (or leaked, see CONFIGURATION).
//     step_start while busy is ignored (no queueing).
//   DONE: one cycle, busy=0, step_done=1, spk_vec final; then IDLE.
//   Latency: step_start at edge t -> neuron i evaluated cycle t+1+i; its spike
//     event at t+2+i; step_done high in cycle t+N_NEURONS+1.
//   spk_vec holds until next step_start or reset.
// CONFIGURATION
//   LIF_LEAK_EN defined: non-firing neuron in SCAN gets
//     mem <= mem - (mem >> LEAK_SHIFT) in its evaluation cycle.
//   Undefined: non-firing mem unchanged (pure integrate-and-fire).
//   Interface and timing identical in both builds.
// TESTING
//   Reset: assert rst_n=0 mid-scan -> all outputs 0, syn_ready=1, no step_done.
//   thr=10, w=+10 to n3, step -> spk_valid with spk_idx=3 at t+5,
//     spk_vec=16'h0008, step_done at t+17, mem[3]=0.
//   thr=10, w=+9 to n5, step -> no spike, mem[5]=9 (no LEAK_EN);
//     add +1, step -> fires.
//   Saturation: n0 200 then +100 -> 255; n1 20 then -50 -> 0;
//     thr=10, mem=200 -> fires; thr=-1, mem=0 -> fires.
//   step_start repeated while busy -> ignored, single step_done;
//     syn_valid during SCAN -> syn_ready=0, weight held until IDLE.
//   LIF_LEAK_EN, shift 3, mem=80, thr=100 -> mem=70 after step.

Source files
------------

// File: rtl/lif_spike_scheduler.sv
// Time-multiplexed LIF neuron layer: integrates weights, sweeps one comparator.
// Optional build macro LIF_LEAK_EN enables leak of non-firing neurons.
module lif_spike_scheduler #(
    parameter int N_NEURONS  = 16,
    parameter int IDX_W      = 4,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           threshold,
    input  logic                 syn_valid,
    output logic                 syn_ready,
    input  logic [IDX_W-1:0]     syn_idx,
    input  logic [7:0]           syn_weight,
    input  logic                 step_start,
    output logic                 busy,
    output logic                 step_done,
    output logic                 spk_valid,
    output logic [IDX_W-1:0]     spk_idx,
    output logic [N_NEURONS-1:0] spk_vec
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [IDX_W:0]   N_LIM = (IDX_W+1)'(N_NEURONS);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_NEURONS - 1);
`ifdef LIF_LEAK_EN
    localparam bit LEAK_EN = 1'b1;
`else
    localparam bit LEAK_EN = 1'b0;
`endif

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [7:0]           thr_q, thr_d;
    logic [7:0]           mem_q [N_NEURONS];
    logic [7:0]           mem_d [N_NEURONS];
    logic [N_NEURONS-1:0] vec_q, vec_d;
    logic                 spk_valid_q, spk_valid_d;
    logic [IDX_W-1:0]     spk_idx_q, spk_idx_d;

    logic                 syn_hit;
    logic signed [9:0]    acc;
    logic [7:0]           acc_sat;
    logic [7:0]           cur_mem;
    logic [7:0]           leak_mem;
    logic                 fire;

    // Weight add is done in 10-bit signed so over/underflow clamps instead of wrapping
    always_comb begin
        syn_hit = syn_valid && (state_q == IDLE) && ({1'b0, syn_idx} < N_LIM);
        acc = $signed({2'b00, mem_q[syn_idx]})
            + $signed({{2{syn_weight[7]}}, syn_weight});
        if (acc[9]) begin
            acc_sat = 8'd0;
        end else if (acc[8]) begin
            acc_sat = 8'd255;
        end else begin
            acc_sat = acc[7:0];
        end
        cur_mem  = mem_q[ptr_q];
        fire     = $signed({1'b0, cur_mem}) >= $signed({thr_q[7], thr_q});
        leak_mem = LEAK_EN ? cur_mem - (cur_mem >> LEAK_SHIFT) : cur_mem;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (step_start) state_d = SCAN;
            SCAN:    if (ptr_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        syn_ready = (state_q == IDLE);
        busy      = (state_q == SCAN);
        step_done = (state_q == DONE);
        spk_valid = spk_valid_q;
        spk_idx   = spk_idx_q;
        spk_vec   = vec_q;
    end

    always_comb begin
        mem_d       = mem_q;
        thr_d       = thr_q;
        vec_d       = vec_q;
        ptr_d       = ptr_q;
        spk_valid_d = 1'b0;
        spk_idx_d   = spk_idx_q;
        if (syn_hit) begin
            mem_d[syn_idx] = acc_sat;
        end
        if (state_q == IDLE && step_start) begin
            thr_d = threshold;
            vec_d = '0;
            ptr_d = '0;
        end
        if (state_q == SCAN) begin
            ptr_d = ptr_q + 1'b1;
            if (fire) begin
                mem_d[ptr_q] = 8'd0;
                vec_d[ptr_q] = 1'b1;
                spk_valid_d  = 1'b1;
                spk_idx_d    = ptr_q;
            end else begin
                mem_d[ptr_q] = leak_mem;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) mem_q[i] <= 8'd0;
            ptr_q       <= '0;
            thr_q       <= 8'd0;
            vec_q       <= '0;
            spk_valid_q <= 1'b0;
            spk_idx_q   <= '0;
        end else begin
            mem_q       <= mem_d;
            ptr_q       <= ptr_d;
            thr_q       <= thr_d;
            vec_q       <= vec_d;
            spk_valid_q <= spk_valid_d;
            spk_idx_q   <= spk_idx_d;
        end
    end

endmodule

// File: tb/tb_lif_spike_scheduler.sv
// Randomized bench for lif_spike_scheduler against an array-based LIF model.
// Honours LIF_LEAK_EN in the model when the design is built with it.
module tb_lif_spike_scheduler;

    localparam int N  = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    threshold = 8'd0;
    logic          syn_valid = 1'b0;
    logic          syn_ready;
    logic [IW-1:0] syn_idx = '0;
    logic [7:0]    syn_weight = 8'd0;
    logic          step_start = 1'b0;
    logic          busy;
    logic          step_done;
    logic          spk_valid;
    logic [IW-1:0] spk_idx;
    logic [N-1:0]  spk_vec;

    int checks = 0;
    int errors = 0;
    int model_mem [N];

    lif_spike_scheduler #(.N_NEURONS(N), .IDX_W(IW), .LEAK_SHIFT(3)) dut (
        .clk(clk), .rst_n(rst_n), .threshold(threshold),
        .syn_valid(syn_valid), .syn_ready(syn_ready), .syn_idx(syn_idx),
        .syn_weight(syn_weight), .step_start(step_start), .busy(busy),
        .step_done(step_done), .spk_valid(spk_valid), .spk_idx(spk_idx),
        .spk_vec(spk_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_syn(input logic [IW-1:0] idx, input logic [7:0] w);
        int s;
        if (int'(idx) < N) begin
            s = model_mem[idx] + int'($signed(w));
            if (s < 0) s = 0;
            if (s > 255) s = 255;
            model_mem[idx] = s;
        end
    endtask

    function automatic logic [N-1:0] model_step(input logic [7:0] thr);
        logic [N-1:0] v;
        int t;
        v = '0;
        t = int'($signed(thr));
        for (int i = 0; i < N; i++) begin
            if (model_mem[i] >= t) begin
                v[i] = 1'b1;
                model_mem[i] = 0;
            end else begin
`ifdef LIF_LEAK_EN
                model_mem[i] = model_mem[i] - model_mem[i] / 8;
`endif
            end
        end
        return v;
    endfunction

    task automatic send(input logic [IW-1:0] idx, input logic [7:0] w);
        @(negedge clk);
        syn_valid  = 1'b1;
        syn_idx    = idx;
        syn_weight = w;
        check("syn_ready_idle", 32'(syn_ready), 32'd1);
        @(posedge clk);
        model_syn(idx, w);
        #1 syn_valid = 1'b0;
    endtask

    task automatic do_step(input logic [7:0] thr, input bit with_syn,
                           input logic [IW-1:0] sidx, input logic [7:0] sw,
                           input bit stress);
        logic [N-1:0] ev;
        @(negedge clk);
        threshold  = thr;
        step_start = 1'b1;
        if (with_syn) begin
            syn_valid  = 1'b1;
            syn_idx    = sidx;
            syn_weight = sw;
            model_syn(sidx, sw);
        end
        ev = model_step(thr);
        @(posedge clk);
        #1;
        step_start = 1'b0;
        syn_valid  = 1'b0;
        threshold  = 8'($urandom);
        @(negedge clk);
        check("busy_start", 32'(busy), 32'd1);
        check("vec_clear", 32'(spk_vec), 32'd0);
        check("spk_valid_start", 32'(spk_valid), 32'd0);
        for (int j = 0; j <= N; j++) begin
            if (stress) begin
                if (j == 2) begin
                    syn_valid  = 1'b1;
                    syn_idx    = 4'd9;
                    syn_weight = 8'd5;
                end
                step_start = (j >= 3 && j <= 5);
            end
            @(posedge clk);
            @(negedge clk);
            check("spk_valid", 32'(spk_valid), 32'((j < N) ? ev[j] : 1'b0));
            if (j < N && ev[j]) check("spk_idx", 32'(spk_idx), 32'(j));
            check("step_done", 32'(step_done), 32'(j == N - 1));
            check("busy", 32'(busy), 32'(j < N - 1));
            check("syn_ready", 32'(syn_ready), 32'(j == N));
        end
        check("spk_vec", 32'(spk_vec), 32'(ev));
        if (stress) begin
            @(posedge clk);
            model_syn(4'd9, 8'd5);
            #1 syn_valid = 1'b0;
            for (int k = 0; k < N + 2; k++) begin
                @(negedge clk);
                check("no_restart_done", 32'(step_done), 32'd0);
                check("no_restart_busy", 32'(busy), 32'd0);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) model_mem[i] = 0;
        #12;
        check("rst_ready", 32'(syn_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(step_done), 32'd0);
        check("rst_spk", 32'(spk_valid), 32'd0);
        check("rst_vec", 32'(spk_vec), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send(4'd3, 8'd10);
        do_step(8'd10, 1'b0, '0, '0, 1'b0);

        send(4'd5, 8'd9);
        do_step(8'd10, 1'b0, '0, '0, 1'b0);
        send(4'd5, 8'd1);
        do_step(8'd10, 1'b0, '0, '0, 1'b0);

        send(4'd0, 8'd100);
        send(4'd0, 8'd100);
        send(4'd0, 8'd100);
        send(4'd1, 8'd20);
        send(4'd1, 8'hCE);
        do_step(8'd100, 1'b0, '0, '0, 1'b0);
        send(4'd2, 8'd10);
        send(4'd2, 8'd127);
        send(4'd2, 8'd127);
        do_step(8'd127, 1'b0, '0, '0, 1'b0);
        do_step(8'hFF, 1'b0, '0, '0, 1'b0);

        send(4'd4, 8'd30);
        do_step(8'd20, 1'b0, '0, '0, 1'b1);
        do_step(8'd12, 1'b1, 4'd6, 8'd12, 1'b0);

        for (int r = 0; r < 8; r++) begin
            int ns;
            ns = $urandom_range(1, 10);
            for (int s = 0; s < ns; s++) send(IW'($urandom), 8'($urandom));
            if (r % 4 == 3) do_step(8'($urandom), 1'b0, '0, '0, 1'b0);
            else do_step(8'($urandom_range(0, 90)), 1'b0, '0, '0, 1'b0);
        end

        for (int i = 0; i < N; i++) send(IW'(i), 8'd60);
        @(negedge clk);
        threshold  = 8'd0;
        step_start = 1'b1;
        @(posedge clk);
        #1 step_start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(syn_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(step_done), 32'd0);
        check("mid_rst_spk", 32'(spk_valid), 32'd0);
        check("mid_rst_idx", 32'(spk_idx), 32'd0);
        check("mid_rst_vec", 32'(spk_vec), 32'd0);
        for (int i = 0; i < N; i++) model_mem[i] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < N + 3; k++) begin
            @(negedge clk);
            check("post_rst_done", 32'(step_done), 32'd0);
            check("post_rst_spk", 32'(spk_valid), 32'd0);
        end
        do_step(8'd1, 1'b0, '0, '0, 1'b0);

        send(4'd7, 8'd80);
        do_step(8'd100, 1'b0, '0, '0, 1'b0);
        do_step(8'd70, 1'b0, '0, '0, 1'b0);
        do_step(8'd1, 1'b0, '0, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
